// File: rtl/multi_channel_comparator.sv
// Multi-channel timestamp comparator: each channel fetches a target from its FIFO and
// fires a PULSE_LEN-cycle trigger once a shared wrapping count reaches it.
module multi_channel_comparator #(
  parameter int WIDTH        = 8,
  parameter int NUM_CH       = 2,
  parameter int READ_LATENCY = 1,
  parameter int PULSE_LEN    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [WIDTH-1:0]        count,
  input  logic [NUM_CH-1:0]       empty,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]       req_data,
  output logic [NUM_CH-1:0]       trigger,
  output logic [NUM_CH-1:0]       late,
  output logic [NUM_CH-1:0]       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REQ       = 3'd1;
  localparam logic [2:0] WAIT_DATA = 3'd2;
  localparam logic [2:0] ARM       = 3'd3;
  localparam logic [2:0] FIRE      = 3'd4;

  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int PUL_W = $clog2(PULSE_LEN + 1);

  // Reset is released synchronously: channels stay parked until this flop sets.
  logic run_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [2:0]       state_reg, state_next;
      logic [WIDTH-1:0] target_reg, target_next;
      logic [WIDTH-1:0] diff;
      logic [LAT_W-1:0] lat_reg, lat_next;
      logic [PUL_W-1:0] pulse_reg, pulse_next;
      logic             late_next;
      logic             req_reg, trig_reg, late_reg, busy_reg;

      // Signed-distance test: the lower half of the modular range counts as reached.
      assign diff = count - target_reg;

      always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        lat_next    = lat_reg;
        pulse_next  = pulse_reg;
        late_next   = 1'b0;
        case (state_reg)
          IDLE: begin
            if (enable && !empty[gi]) begin
              state_next = REQ;
            end
          end
          REQ: begin
            state_next = WAIT_DATA;
            lat_next   = '0;
          end
          WAIT_DATA: begin
            if (lat_reg == LAT_W'(READ_LATENCY - 1)) begin
              target_next = data_in[gi*WIDTH +: WIDTH];
              state_next  = ARM;
            end else begin
              lat_next = lat_reg + LAT_W'(1);
            end
          end
          ARM: begin
            if (!diff[WIDTH-1]) begin
              state_next = FIRE;
              late_next  = |diff;
              pulse_next = '0;
            end
          end
          FIRE: begin
            if (pulse_reg == PUL_W'(PULSE_LEN - 1)) begin
              state_next = IDLE;
            end else begin
              pulse_next = pulse_reg + PUL_W'(1);
            end
          end
          default: state_next = IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg  <= IDLE;
          target_reg <= '0;
          lat_reg    <= '0;
          pulse_reg  <= '0;
          req_reg    <= 1'b0;
          trig_reg   <= 1'b0;
          late_reg   <= 1'b0;
          busy_reg   <= 1'b0;
        end else if (!run_reg) begin
          state_reg  <= IDLE;
          target_reg <= '0;
          lat_reg    <= '0;
          pulse_reg  <= '0;
          req_reg    <= 1'b0;
          trig_reg   <= 1'b0;
          late_reg   <= 1'b0;
          busy_reg   <= 1'b0;
        end else begin
          state_reg  <= state_next;
          target_reg <= target_next;
          lat_reg    <= lat_next;
          pulse_reg  <= pulse_next;
          req_reg    <= (state_next == REQ);
          trig_reg   <= (state_next == FIRE);
          late_reg   <= late_next;
          busy_reg   <= (state_next != IDLE);
        end
      end

      assign req_data[gi] = req_reg;
      assign trigger[gi]  = trig_reg;
      assign late[gi]     = late_reg;
      assign busy[gi]     = busy_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_channel_comparator.sv
// Directed bench for multi_channel_comparator: count advances 1/clk, FIFOs modelled as queues.
module tb_multi_channel_comparator;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  count;
  logic [1:0]  empty;
  logic [15:0] data_in;
  logic [1:0]  req_data;
  logic [1:0]  trigger;
  logic [1:0]  late;
  logic [1:0]  busy;

  int checks = 0;
  int fails  = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  multi_channel_comparator #(
    .WIDTH(8), .NUM_CH(2), .READ_LATENCY(1), .PULSE_LEN(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .count(count), .empty(empty),
    .data_in(data_in), .req_data(req_data), .trigger(trigger), .late(late), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: count steps like a register, FIFO pops on a strobe seen in the previous cycle.
  task automatic tick();
    logic [1:0] r;
    r = req_data;
    @(posedge clk);
    #1;
    count = count + 8'd1;
    if (r[0]) begin
      checks++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL read_empty ch0: req_data=1 required empty fifo untouched");
      end else data_in[7:0] = q0.pop_front();
    end
    if (r[1]) begin
      checks++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL read_empty ch1: req_data=1 required empty fifo untouched");
      end else data_in[15:8] = q1.pop_front();
    end
    empty = {q1.size() == 0, q0.size() == 0};
  endtask

  task automatic push(input int ch, input logic [7:0] v);
    if (ch == 0) q0.push_back(v);
    else q1.push_back(v);
    empty = {q1.size() == 0, q0.size() == 0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; count = 8'h00; empty = 2'b11; data_in = 16'h0;
    repeat (3) tick();
    checks++; if (req_data !== 2'b00) begin fails++; $display("FAIL reset_req: got %b expected 00", req_data); end
    checks++; if (trigger !== 2'b00) begin fails++; $display("FAIL reset_trig: got %b expected 00", trigger); end
    checks++; if (late !== 2'b00) begin fails++; $display("FAIL reset_late: got %b expected 00", late); end
    checks++; if (busy !== 2'b00) begin fails++; $display("FAIL reset_busy: got %b expected 00", busy); end
    rst_n = 1'b1;
    repeat (3) tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int nreq = 0;
    logic exp_t;
    count = 8'h10; enable = 1'b1;
    push(0, 8'h40);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (req_data[0]) nreq++;
      exp_t = (count == 8'h41) || (count == 8'h42);
      checks++;
      if (trigger[0] !== exp_t) begin fails++; $display("FAIL basic_trig at count %0h: got %b expected %b", count, trigger[0], exp_t); end
      checks++;
      if (late[0] !== 1'b0) begin fails++; $display("FAIL basic_late at count %0h: got %b expected 0", count, late[0]); end
    end
    checks++; if (nreq != 1) begin fails++; $display("FAIL basic_req_count: got %0d expected 1", nreq); end
    checks++; if (busy !== 2'b00) begin fails++; $display("FAIL basic_busy_end: got %b expected 00", busy); end
    $display("test_basic done");
  endtask

  task automatic test_late();
    logic exp_t, exp_l;
    count = 8'h1E;
    push(0, 8'h05);
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_t = (count == 8'h22) || (count == 8'h23);
      exp_l = (count == 8'h22);
      checks++;
      if (trigger[0] !== exp_t) begin fails++; $display("FAIL late_trig at count %0h: got %b expected %b", count, trigger[0], exp_t); end
      checks++;
      if (late[0] !== exp_l) begin fails++; $display("FAIL late_flag at count %0h: got %b expected %b", count, late[0], exp_l); end
    end
    $display("test_late done");
  endtask

  task automatic test_wrap();
    logic exp_t;
    count = 8'hEE;
    push(0, 8'h10);
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_t = (count == 8'h11) || (count == 8'h12);
      checks++;
      if (trigger[0] !== exp_t) begin fails++; $display("FAIL wrap_trig at count %0h: got %b expected %b", count, trigger[0], exp_t); end
      checks++;
      if (late[0] !== 1'b0) begin fails++; $display("FAIL wrap_late at count %0h: got %b expected 0", count, late[0]); end
    end
    $display("test_wrap done");
  endtask

  task automatic test_simultaneous();
    logic exp_t;
    count = 8'h70;
    push(0, 8'h80);
    push(1, 8'h80);
    for (int i = 0; i < 30; i++) begin
      tick();
      exp_t = (count == 8'h81) || (count == 8'h82);
      checks++;
      if (trigger !== {exp_t, exp_t}) begin fails++; $display("FAIL simul_trig at count %0h: got %b expected %b%b", count, trigger, exp_t, exp_t); end
      checks++;
      if (late !== 2'b00) begin fails++; $display("FAIL simul_late at count %0h: got %b expected 00", count, late); end
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_enable_gate();
    logic exp0, exp1;
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (req_data !== 2'b00) begin fails++; $display("FAIL gate_empty_req cycle %0d: got %b expected 00", i, req_data); end
    end
    enable = 1'b0;
    push(0, 8'h40);
    push(1, 8'h41);
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (req_data !== 2'b00 || busy !== 2'b00) begin
        fails++; $display("FAIL gate_disabled cycle %0d: got req=%b busy=%b expected 00/00", i, req_data, busy);
      end
    end
    count = 8'h30;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 2) enable = 1'b0;
      exp0 = (count == 8'h41) || (count == 8'h42);
      exp1 = (count == 8'h42) || (count == 8'h43);
      checks++;
      if (trigger !== {exp1, exp0}) begin fails++; $display("FAIL gate_armed_trig at count %0h: got %b expected %b%b", count, trigger, exp1, exp0); end
    end
    $display("test_enable_gate done");
  endtask

  task automatic test_reset_mid_fire();
    int n = 0;
    enable = 1'b1;
    count = 8'h50;
    push(0, 8'h60);
    while (trigger[0] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (trigger[0] !== 1'b1) begin fails++; $display("FAIL midfire_timeout: got trigger=%b expected 1 within 40 cycles", trigger[0]); end
    rst_n = 1'b0;
    #1;
    checks++; if (trigger !== 2'b00) begin fails++; $display("FAIL midfire_trig: got %b expected 00", trigger); end
    checks++; if (busy !== 2'b00) begin fails++; $display("FAIL midfire_busy: got %b expected 00", busy); end
    checks++; if (late !== 2'b00) begin fails++; $display("FAIL midfire_late: got %b expected 00", late); end
    repeat (2) tick();
    push(0, 8'h90);
    rst_n = 1'b1;
    tick();
    checks++; if (req_data[0] !== 1'b0) begin fails++; $display("FAIL release_req_c1: got %b expected 0", req_data[0]); end
    tick();
    checks++; if (req_data[0] !== 1'b1) begin fails++; $display("FAIL release_req_c2: got %b expected 1", req_data[0]); end
    tick();
    checks++; if (req_data[0] !== 1'b0) begin fails++; $display("FAIL release_req_c3: got %b expected 0", req_data[0]); end
    $display("test_reset_mid_fire done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_late();
    test_wrap();
    test_simultaneous();
    test_enable_gate();
    test_reset_mid_fire();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
